// File: rtl/nibble_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : nibble_add_sequencer
// Function : Sequences a wide add through an external 4-bit combinational
//            adder, one nibble per cycle, LSB nibble first.
// Option   : NIBBLE_SEQ_SUB_EN adds inSub (A - B via inverted B, carry-in 1).
// Revision : 1.0 - initial release
// ============================================================================
module nibble_add_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inStart,
    input  logic [4*NIBBLES-1:0]   inA,
    input  logic [4*NIBBLES-1:0]   inB,
    input  logic                   carryIn,
`ifdef NIBBLE_SEQ_SUB_EN
    input  logic                   inSub,
`endif
    output logic                   inReady,
    output logic [3:0]             nibA,
    output logic [3:0]             nibB,
    output logic                   nibCarryIn,
    input  logic [3:0]             nibSum,
    input  logic                   nibCarryOut,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   carryOut
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = $clog2(NIBBLES);
    localparam logic [IDXW-1:0] c_LastIdx = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } stateT;

    stateT             r_state;
    stateT             w_nextState;
    logic              w_accept;
    logic              w_last;

    logic [W-1:0]      r_opA;
    logic [W-1:0]      r_opB;
    logic              r_cin;
    logic              r_carry;
    logic [IDXW-1:0]   r_index;
    logic [W-1:0]      r_sum;
    logic              r_carryOut;
    logic [3:0]        w_bNib;
    logic              w_invB;

`ifdef NIBBLE_SEQ_SUB_EN
    logic              r_sub;
    assign w_invB = r_sub;
`else
    assign w_invB = 1'b0;
`endif

    assign w_bNib   = r_opB[{r_index, 2'b00} +: 4];
    assign w_last   = (r_index == c_LastIdx);
    assign sum      = r_sum;
    assign carryOut = r_carryOut;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Start and completion handshakes are mutually exclusive by state,
    // so a start coinciding with outReady in DONE is never accepted.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        inReady     = 1'b0;
        outValid    = 1'b0;
        nibA        = 4'd0;
        nibB        = 4'd0;
        nibCarryIn  = 1'b0;
        case (r_state)
            S_IDLE: begin
                inReady = 1'b1;
                if (inStart) begin
                    w_accept    = 1'b1;
                    w_nextState = S_RUN;
                end
            end
            S_RUN: begin
                nibA       = r_opA[{r_index, 2'b00} +: 4];
                nibB       = w_invB ? ~w_bNib : w_bNib;
                nibCarryIn = (r_index == '0) ? r_cin : r_carry;
                if (w_last) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                outValid = 1'b1;
                if (outReady) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_opA      <= '0;
            r_opB      <= '0;
            r_cin      <= 1'b0;
            r_carry    <= 1'b0;
            r_index    <= '0;
            r_sum      <= '0;
            r_carryOut <= 1'b0;
`ifdef NIBBLE_SEQ_SUB_EN
            r_sub      <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_opA   <= inA;
                r_opB   <= inB;
                r_index <= '0;
`ifdef NIBBLE_SEQ_SUB_EN
                r_sub   <= inSub;
                r_cin   <= inSub | carryIn;
`else
                r_cin   <= carryIn;
`endif
            end
            if (r_state == S_RUN) begin
                r_sum[{r_index, 2'b00} +: 4] <= nibSum;
                r_carry <= nibCarryOut;
                if (w_last) begin
                    r_carryOut <= nibCarryOut;
                    r_index    <= '0;
                end else begin
                    r_index    <= r_index + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
